// File: rtl/fft_out_collect_if.sv
// fft_out_collect_if: FFT sample stream into the collector and reordered stream out of it
//   in_real/in_img/in_start  : FFT stage output, in_start marks sample 0
//   out_real/out_img         : natural-order samples, zero when out_valid is low
//   out_valid/out_start/out_over : output framing (valid, first sample, last sample)
//   err_ovf                  : sticky dropped-frame flag
interface fft_out_collect_if #(parameter int DW = 32);
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_img;
  logic          in_start;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_img;
  logic          out_valid;
  logic          out_start;
  logic          out_over;
  logic          err_ovf;
  modport master (
    output in_real, in_img, in_start,
    input  out_real, out_img, out_valid, out_start, out_over, err_ovf
  );
  modport slave (
    input  in_real, in_img, in_start,
    output out_real, out_img, out_valid, out_start, out_over, err_ovf
  );
endinterface

// File: rtl/fft_out_collect.sv
// fft_out_collect: ping-pong bit-reversal collector replaying FFT frames in natural order
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : fft_out_collect_if.slave (input stream, reordered output stream, err_ovf)
module fft_out_collect #(
  parameter int LAYER = 3,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              rst,
  fft_out_collect_if.slave bus
);
  localparam int N = 1 << LAYER;
  localparam logic [LAYER-1:0] LAST = LAYER'(N - 1);
  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_t;
  w_state_t         r_wstate, w_wstate_nx;
  r_state_t         r_rstate, w_rstate_nx;
  logic [LAYER-1:0] r_wcnt, w_wcnt_nx, w_widx, r_raddr, w_raddr_nx;
  logic             r_wsel, r_rsel, r_err;
  logic [1:0]       r_full;
  logic             w_we, w_set, w_clr, w_rel, w_free, w_ovf;
  logic [2*DW-1:0]  r_mem [2][N];
  logic [DW-1:0]    r_out_real, r_out_img;
  logic             r_out_valid, r_out_start, r_out_over;

  function automatic logic [LAYER-1:0] bitrev(input logic [LAYER-1:0] k);
    logic [LAYER-1:0] rev;
    rev = '0;
    for (int i = 0; i < LAYER; i++) rev[i] = k[LAYER-1-i];
    return rev;
  endfunction

  // A bank whose last address is being read this cycle counts as free, so a
  // frame starting right behind a drain is accepted and back-to-back input
  // streams never lose a frame.
  assign w_rel  = r_rstate == R_DRAIN && r_raddr == LAST;
  assign w_free = !r_full[r_wsel] || (w_rel && r_rsel == r_wsel);

  always_comb begin
    w_wstate_nx = r_wstate;
    w_wcnt_nx   = r_wcnt;
    w_widx      = r_wcnt;
    w_we        = 1'b0;
    w_set       = 1'b0;
    w_ovf       = 1'b0;
    if (bus.in_start) begin
      w_we        = w_free;
      w_ovf       = !w_free;
      w_widx      = '0;
      w_wcnt_nx   = w_free ? LAYER'(1) : '0;
      w_wstate_nx = w_free ? W_FILL : W_IDLE;
    end else if (r_wstate == W_FILL) begin
      w_we        = 1'b1;
      w_wcnt_nx   = r_wcnt + LAYER'(1);
      w_set       = r_wcnt == LAST;
      w_wstate_nx = w_set ? W_IDLE : W_FILL;
    end
  end

  // On the last address, stay in R_DRAIN if the other bank is already full so
  // consecutive output frames are contiguous.
  always_comb begin
    w_rstate_nx = r_rstate;
    w_raddr_nx  = r_raddr;
    w_clr       = 1'b0;
    if (r_rstate == R_IDLE) begin
      w_rstate_nx = r_full[r_rsel] ? R_DRAIN : R_IDLE;
      w_raddr_nx  = '0;
    end else begin
      w_raddr_nx  = r_raddr + LAYER'(1);
      w_clr       = w_rel;
      if (w_rel) w_rstate_nx = r_full[~r_rsel] ? R_DRAIN : R_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate    <= W_IDLE;
      r_rstate    <= R_IDLE;
      r_wcnt      <= '0;
      r_raddr     <= '0;
      r_wsel      <= 1'b0;
      r_rsel      <= 1'b0;
      r_full      <= 2'b00;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_start <= 1'b0;
      r_out_over  <= 1'b0;
      r_out_real  <= '0;
      r_out_img   <= '0;
    end else begin
      r_wstate    <= w_wstate_nx;
      r_rstate    <= w_rstate_nx;
      r_wcnt      <= w_wcnt_nx;
      r_raddr     <= w_raddr_nx;
      r_wsel      <= r_wsel ^ w_set;
      r_rsel      <= r_rsel ^ w_clr;
      r_full      <= (r_full | {w_set & r_wsel, w_set & ~r_wsel}) & ~{w_clr & r_rsel, w_clr & ~r_rsel};
      r_err       <= r_err | w_ovf;
      r_out_valid <= r_rstate == R_DRAIN;
      r_out_start <= r_rstate == R_DRAIN && r_raddr == '0;
      r_out_over  <= w_rel;
      {r_out_real, r_out_img} <= r_rstate == R_DRAIN ? r_mem[r_rsel][r_raddr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wsel][bitrev(w_widx)] <= {bus.in_real, bus.in_img};
  end

  assign bus.out_real  = r_out_real;
  assign bus.out_img   = r_out_img;
  assign bus.out_valid = r_out_valid;
  assign bus.out_start = r_out_start;
  assign bus.out_over  = r_out_over;
  assign bus.err_ovf   = r_err;
endmodule

// File: tb/tb_fft_out_collect.sv
// tb_fft_out_collect: randomized scoreboard bench for fft_out_collect (LAYER=3/DW=32 and LAYER=4/DW=16)
module tb_fft_out_collect;
  localparam int NA = 8;
  localparam int NB = 16;
  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    bit          st;
    bit          ov;
    int          cyc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  item_t qa[$];
  item_t qb[$];
  int    pend[$];
  int    m_last = -100;
  int    m_cnt = 0;
  bit    m_fill = 1'b0;
  bit    m_ovf = 1'b0;
  logic [31:0] m_re [NA];
  logic [31:0] m_im [NA];

  fft_out_collect_if #(.DW(32)) ia ();
  fft_out_collect_if #(.DW(16)) ib ();

  fft_out_collect #(.LAYER(3), .DW(32)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  fft_out_collect #(.LAYER(4), .DW(16)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int brev(input int k, input int l);
    int r = 0;
    for (int i = 0; i < l; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame finished at cycle cyc: its drain starts two cycles later, or right
  // after the previous drain if that one is still running.
  task automatic complete_a();
    int d;
    item_t e;
    d = (cyc + 2 > m_last + 1) ? cyc + 2 : m_last + 1;
    m_last = d + NA - 1;
    pend.push_back(m_last);
    for (int a = 0; a < NA; a++) begin
      e.re  = m_re[brev(a, 3)];
      e.im  = m_im[brev(a, 3)];
      e.st  = (a == 0);
      e.ov  = (a == NA - 1);
      e.cyc = d + 1 + a;
      qa.push_back(e);
    end
    m_fill = 1'b0;
  endtask

  task automatic step(input bit st, input logic [31:0] re, input logic [31:0] im);
    @(negedge clk);
    ia.in_start = st;
    ia.in_real  = re;
    ia.in_img   = im;
    if (st) begin
      while (pend.size() > 0 && pend[0] <= cyc) void'(pend.pop_front());
      if (pend.size() < 2) begin
        m_fill = 1'b1;
        m_cnt  = 0;
      end else begin
        m_fill = 1'b0;
        m_ovf  = 1'b1;
      end
    end
    if (m_fill) begin
      m_re[m_cnt] = re;
      m_im[m_cnt] = im;
      m_cnt++;
      if (m_cnt == NA) complete_a();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom, $urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 400) begin
      step(1'b0, $urandom, $urandom);
      n++;
    end
    check("drain_timeout", 64'(qa.size() + qb.size()), 64'd0);
    idle(4);
  endtask

  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (qa.size() > 0 && qa[0].cyc < cyc) begin
          e = qa.pop_front();
          vectors++;
          errors++;
          $display("FAIL A_missing got nothing at cyc %0d expected re %0h", e.cyc, e.re);
        end
        if (ia.out_valid) begin
          vectors++;
          if (qa.size() == 0) begin
            errors++;
            $display("FAIL A_extra got re %0h at cyc %0d expected no output", ia.out_real, cyc);
          end else begin
            e = qa.pop_front();
            if ({ia.out_real, ia.out_img, ia.out_start, ia.out_over} !== {e.re, e.im, e.st, e.ov} || e.cyc != cyc) begin
              errors++;
              $display("FAIL A_sample got re %0h im %0h st %0b ov %0b cyc %0d expected re %0h im %0h st %0b ov %0b cyc %0d",
                       ia.out_real, ia.out_img, ia.out_start, ia.out_over, cyc, e.re, e.im, e.st, e.ov, e.cyc);
            end
          end
        end else begin
          vectors++;
          if ({ia.out_real, ia.out_img, ia.out_start, ia.out_over} !== '0) begin
            errors++;
            $display("FAIL A_idle got re %0h im %0h st %0b ov %0b expected all 0", ia.out_real, ia.out_img, ia.out_start, ia.out_over);
          end
        end
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
          e = qb.pop_front();
          vectors++;
          errors++;
          $display("FAIL B_missing got nothing at cyc %0d expected re %0h", e.cyc, e.re);
        end
        if (ib.out_valid) begin
          vectors++;
          if (qb.size() == 0) begin
            errors++;
            $display("FAIL B_extra got re %0h at cyc %0d expected no output", ib.out_real, cyc);
          end else begin
            e = qb.pop_front();
            if ({16'b0, ib.out_real, 16'b0, ib.out_img, ib.out_start, ib.out_over} !== {e.re, e.im, e.st, e.ov} || e.cyc != cyc) begin
              errors++;
              $display("FAIL B_sample got re %0h im %0h st %0b ov %0b cyc %0d expected re %0h im %0h st %0b ov %0b cyc %0d",
                       ib.out_real, ib.out_img, ib.out_start, ib.out_over, cyc, e.re, e.im, e.st, e.ov, e.cyc);
            end
          end
        end else begin
          vectors++;
          if ({ib.out_real, ib.out_img, ib.out_start, ib.out_over} !== '0) begin
            errors++;
            $display("FAIL B_idle got re %0h im %0h st %0b ov %0b expected all 0", ib.out_real, ib.out_img, ib.out_start, ib.out_over);
          end
        end
      end
    end
  end

  initial begin
    int tgt, t, len, gap;
    item_t e;
    ia.in_start = 1'b0;
    ia.in_real  = '0;
    ia.in_img   = '0;
    ib.in_start = 1'b0;
    ib.in_real  = '0;
    ib.in_img   = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_data_a", {ia.out_real, ia.out_img}, 64'd0);
    check("rst_ctl_a", 64'({ia.out_valid, ia.out_start, ia.out_over, ia.err_ovf}), 64'd0);
    check("rst_data_b", 64'({ib.out_real, ib.out_img}), 64'd0);
    check("rst_ctl_b", 64'({ib.out_valid, ib.out_start, ib.out_over, ib.err_ovf}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    for (int k = 0; k < NA; k++) step(k == 0, 32'(k), 32'(100 + k));
    wait_drain();

    for (int f = 0; f < 3; f++)
      for (int k = 0; k < NA; k++) step(k == 0, $urandom, $urandom);
    wait_drain();
    check("ovf_after_b2b", 64'(ia.err_ovf), 64'(m_ovf));

    for (int k = 0; k < 5; k++) step(k == 0, $urandom, $urandom);
    for (int k = 0; k < NA; k++) step(k == 0, 32'(50 + k), 32'(150 + k));
    wait_drain();

    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NA - 1) : NA;
      gap = $urandom_range(0, 3);
      for (int k = 0; k < len; k++) step(k == 0, $urandom, $urandom);
      idle(gap);
    end
    wait_drain();
    check("ovf_random", 64'(ia.err_ovf), 64'(m_ovf));

    for (int k = 0; k < NA; k++) step(k == 0, $urandom, $urandom);
    tgt = qa[3].cyc;
    while (cyc < tgt) step(1'b0, $urandom, $urandom);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_data", {ia.out_real, ia.out_img}, 64'd0);
    check("rst_mid_ctl", 64'({ia.out_valid, ia.out_start, ia.out_over, ia.err_ovf}), 64'd0);
    qa.delete();
    pend.delete();
    m_fill = 1'b0;
    m_last = -100;
    m_ovf  = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(20);
    for (int k = 0; k < NA; k++) step(k == 0, $urandom, $urandom);
    wait_drain();

    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      ib.in_start = (k == 0);
      ib.in_real  = 16'(k);
      ib.in_img   = 16'(200 + k);
      if (k == NB - 1) begin
        t = cyc;
        for (int a = 0; a < NB; a++) begin
          e.re  = 32'(brev(a, 4));
          e.im  = 32'(200 + brev(a, 4));
          e.st  = (a == 0);
          e.ov  = (a == NB - 1);
          e.cyc = t + 3 + a;
          qb.push_back(e);
        end
      end
    end
    wait_drain();
    check("ovf_final_a", 64'(ia.err_ovf), 64'(m_ovf));
    check("ovf_final_b", 64'(ib.err_ovf), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
